// File: rtl/quad_adc_interface.sv
`timescale 1ns/1ps
// Deserializer for one channel of a two-lane DDR serial-LVDS ADC.
// Each frame's bit pairs are assembled MSB-first into one word that is presented in the DATA_CLK domain.
module quad_adc_interface #(
   parameter int DATA_WIDTH = 14
) (
   input  logic                  DATA_CLK,
   input  logic                  RESET_N,
   input  logic                  FRAME_CLK,
   input  logic                  CH_X_A,
   input  logic                  CH_X_B,
   output logic [DATA_WIDTH-1:0] CH_X_DATA,
   output logic                  CH_X_VALID
);

   localparam int PAIRS = DATA_WIDTH / 2;
   localparam int CW    = $clog2(PAIRS + 1);

   typedef struct packed {
      logic                  active;
      logic [CW-1:0]         count;
      logic [DATA_WIDTH-1:0] shift;
   } deser_t;

   logic   pos_a, pos_b, pos_f;
   logic   neg_a, neg_b, neg_f;
   logic   frame_prev;
   deser_t cur, mid, nxt;
   logic   done_rise, done_fall;
   logic [DATA_WIDTH-1:0] word_rise, word_fall;

   // Advance the deserializer by one captured edge; a frame start overrides any partial sample.
   function automatic void deser_step(
      input  deser_t                s,
      input  logic                  fp,
      input  logic                  f,
      input  logic                  a,
      input  logic                  b,
      output deser_t                n,
      output logic                  done,
      output logic [DATA_WIDTH-1:0] word
   );
      n    = s;
      done = 1'b0;
      word = {s.shift[DATA_WIDTH-3:0], a, b};
      if (s.active) begin
         n.shift = word;
         n.count = s.count + CW'(1);
         if (s.count == CW'(PAIRS - 1)) begin
            n.active = 1'b0;
            n.count  = '0;
            done     = 1'b1;
         end
      end
      if (f && !fp) begin
         n.active = 1'b1;
         n.count  = CW'(1);
         n.shift  = {{(DATA_WIDTH-2){1'b0}}, a, b};
      end
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge DATA_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pos_a <= 1'b0;
         pos_b <= 1'b0;
         pos_f <= 1'b0;
      end else begin
         pos_a <= CH_X_A;
         pos_b <= CH_X_B;
         pos_f <= FRAME_CLK;
      end
   end

   always_ff @(negedge DATA_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         neg_a <= 1'b0;
         neg_b <= 1'b0;
         neg_f <= 1'b0;
      end else begin
         neg_a <= CH_X_A;
         neg_b <= CH_X_B;
         neg_f <= FRAME_CLK;
      end
   end

   // At each rising edge the previous rising capture precedes the falling capture in edge order.
   always_comb begin
      deser_step(cur, frame_prev, pos_f, pos_a, pos_b, mid, done_rise, word_rise);
      deser_step(mid, pos_f, neg_f, neg_a, neg_b, nxt, done_fall, word_fall);
   end

   // NOTE: the shift register is reset too, so an aborted sample can never leak into a later word.
   always_ff @(posedge DATA_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cur        <= '0;
         frame_prev <= 1'b0;
         CH_X_DATA  <= '0;
         CH_X_VALID <= 1'b0;
      end else begin
         cur        <= nxt;
         frame_prev <= neg_f;
         CH_X_VALID <= done_rise | done_fall;
         if (done_fall)
            CH_X_DATA <= word_fall;
         else if (done_rise)
            CH_X_DATA <= word_rise;
      end
   end

endmodule

// File: tb/tb_quad_adc_interface.sv
`timescale 1ns/1ps
// Self-checking bench for quad_adc_interface: directed DDR frames drive a scoreboard of expected words
// together with their last-pair capture times, so both the value and the output latency are checked.
module tb_quad_adc_interface;

   localparam int W = 14;
   localparam int P = W / 2;

   logic         DATA_CLK = 1'b0;
   logic         RESET_N;
   logic         FRAME_CLK;
   logic         CH_X_A;
   logic         CH_X_B;
   logic [W-1:0] CH_X_DATA;
   logic         CH_X_VALID;

   typedef struct {
      logic [W-1:0] word;
      time          cap_time;
      bit           cap_rising;
   } exp_t;

   exp_t         sb[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   time          last_edge;
   bit           last_cap_rising;
   logic [W-1:0] last_word = '0;

   quad_adc_interface #(.DATA_WIDTH(W)) dut (
      .DATA_CLK  (DATA_CLK),
      .RESET_N   (RESET_N),
      .FRAME_CLK (FRAME_CLK),
      .CH_X_A    (CH_X_A),
      .CH_X_B    (CH_X_B),
      .CH_X_DATA (CH_X_DATA),
      .CH_X_VALID(CH_X_VALID)
   );

   always #5 DATA_CLK = ~DATA_CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one edge slot: inputs change 2 ns after an edge and are captured on the following edge.
   task automatic step(input logic f, input logic a, input logic b);
      @(DATA_CLK);
      last_edge = $time;
      #2;
      FRAME_CLK = f;
      CH_X_A    = a;
      CH_X_B    = b;
      last_cap_rising = (DATA_CLK == 1'b0);
   endtask

   // Idle with FRAME_CLK low until the next slot is captured on the wanted edge type.
   task automatic align(input bit want_rising);
      step(1'b0, 1'b0, 1'b0);
      if (last_cap_rising == want_rising)
         step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [W-1:0] word, input int n_edges, input bit push);
      logic a, b;
      exp_t x;
      for (int e = 0; e < n_edges; e++) begin
         if (e < P) begin
            a = word[W-1-2*e];
            b = word[W-2-2*e];
         end else begin
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
         end
         step(e < (n_edges + 1) / 2, a, b);
         if (push && e == P - 1) begin
            x.word       = word;
            x.cap_time   = last_edge + 5;
            x.cap_rising = last_cap_rising;
            sb.push_back(x);
            last_word = word;
         end
      end
   endtask

   task automatic drain(input string tag);
      repeat (8) step(1'b0, 1'b0, 1'b0);
      check({tag, "_all_seen"}, 32'(sb.size()), 32'd0);
      check({tag, "_hold"}, 32'(CH_X_DATA), 32'(last_word));
   endtask

   always @(negedge DATA_CLK) begin
      exp_t e;
      if (CH_X_VALID === 1'b1) begin
         check("valid_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data", 32'(CH_X_DATA), 32'(e.word));
            check("latency", 32'($time - 5 - e.cap_time), e.cap_rising ? 32'd10 : 32'd5);
         end
      end
   end

   initial begin
      RESET_N   = 1'b1;
      FRAME_CLK = 1'b0;
      CH_X_A    = 1'b0;
      CH_X_B    = 1'b0;
      #1 RESET_N = 1'b0;

      // Reset held with toggling frames and data.
      for (int i = 0; i < 16; i++) begin
         step(i % 4 < 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         #1;
         check("reset_data", 32'(CH_X_DATA), 32'd0);
         check("reset_valid", 32'(CH_X_VALID), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0);
      #1 RESET_N = 1'b1;
      drain("post_reset");

      // Basic capture, frame start on a rising edge.
      align(1'b1);
      send_frame(14'h2AAA, 7, 1'b1);
      drain("basic");

      // Lane mapping with 8-edge frames; the trailing edge carries random data.
      align(1'b1);
      send_frame(14'h1555, 8, 1'b1);
      send_frame(14'h3FFF, 8, 1'b1);
      send_frame(14'h0000, 8, 1'b1);
      drain("lanes");

      // Phase: falling-edge start then rising-edge start.
      align(1'b0);
      send_frame(14'h2001, 7, 1'b1);
      drain("phase_fall");
      align(1'b1);
      send_frame(14'h2001, 7, 1'b1);
      drain("phase_rise");

      // Truncated frame followed by a full one.
      align(1'b1);
      send_frame(14'h3C5A, 4, 1'b0);
      send_frame(14'h1234, 8, 1'b1);
      drain("truncated");

      // Mid-sample reset while pair 3 is on the lanes.
      align(1'b1);
      send_frame(14'h0F0F, 4, 1'b0);
      #1 RESET_N = 1'b0;
      #1;
      check("midreset_data", 32'(CH_X_DATA), 32'd0);
      check("midreset_valid", 32'(CH_X_VALID), 32'd0);
      last_word = '0;
      repeat (3) step(1'b0, 1'b0, 1'b0);
      #1 RESET_N = 1'b1;
      drain("midreset_quiet");
      align(1'b1);
      send_frame(14'h2D5B, 8, 1'b1);
      drain("midreset_recover");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_adc_interface.md
Name: quad_adc_interface

Overview:
- Deserializer for one channel of a quad serial-LVDS ADC. The ADC uses 2 lanes per channel in DDR mode.
- Each conversion is DATA_WIDTH bits. It is sent MSB-first as bit pairs, one pair on every DATA_CLK edge (rising and falling).
- FRAME_CLK marks the start of each sample.
- The block sits between the ADC pins and the sample FIFO/AXI logic. It presents one parallel word per frame in the DATA_CLK domain.

Parameters:
- DATA_WIDTH, 14, sample width in bits; must be even; pairs per sample P = DATA_WIDTH/2 (7).

Ports:
- DATA_CLK  input  1  ADC bit clock, the only clock; both edges are used for capture.
- RESET_N  input  1  asynchronous, active-low reset.
- FRAME_CLK  input  1  ADC frame clock; treated as a data signal sampled by DATA_CLK.
- CH_X_A  input  1  lane A; carries the even offsets from the MSB (bits 13,11,...,1).
- CH_X_B  input  1  lane B; carries bits 12,10,...,0.
- CH_X_DATA  output  DATA_WIDTH  last complete sample, unsigned, held between updates.
- CH_X_VALID  output  1  one-DATA_CLK-cycle pulse when CH_X_DATA updates.

Behaviour:
- Reset (RESET_N=0, async assert): CH_X_DATA=0, CH_X_VALID=0, pair counter idle, shift register cleared, FRAME history=0. Release is taken on DATA_CLK rising edge. The first valid output requires a fresh frame start after release.
- Sampling: on every DATA_CLK edge (rise and fall), register CH_X_A, CH_X_B and FRAME_CLK. The implementation uses a posedge capture set and a negedge capture set, merged into one edge-ordered stream.
- Frame start: detected at edge k when sampled FRAME_CLK=1 at edge k and 0 at edge k-1. The pair captured at edge k is pair 0 (A→bit DATA_WIDTH-1, B→bit DATA_WIDTH-2).
- Pair i (0..P-1): A→bit DATA_WIDTH-1-2i, B→bit DATA_WIDTH-2-2i.
- After pair P-1: the assembled word is loaded into CH_X_DATA on the first DATA_CLK rising edge strictly after that capture edge. CH_X_VALID=1 for exactly that cycle.
- Latency: 1 cycle if the last pair was captured on a rising edge; ½ cycle if it was captured on a falling edge.
- Edges after pair P-1 and before the next frame start are ignored; the counter stays idle.
- Frame start while a sample is incomplete: the partial sample is discarded, the count restarts at pair 0, and no valid pulse is issued for the partial sample.
- Frame start on the same edge as pair P-1 of the previous sample is impossible when the frame period is ≥ P edges. If it happens anyway, the completed word is still output and the new frame starts.
- FRAME_CLK held high: no new frame start, so no further outputs.
- CH_X_DATA holds its value between VALID pulses.
- Async reset mid-sample aborts the sample immediately; no VALID follows.
- No combinational path from inputs to outputs; all outputs are registered on DATA_CLK rising edge.

Test Plan:
- Reset: hold RESET_N=0 with toggling clocks and frames → CH_X_DATA=0 and CH_X_VALID=0 throughout; no output until a frame start after release.
- Basic capture, pattern 0x2AAA: DATA_CLK 10 ns; frame rising before a rising DATA_CLK edge; pairs (A,B) = (1,0)×7 on consecutive edges → CH_X_DATA=0x2AAA, one VALID pulse ½–1 cycle after the 7th edge.
- Lane mapping: word 0x1555, then 0x3FFF, then 0x0000, with 40 ns frames (8 edges, last edge ignored) → outputs 0x1555, 0x3FFF, 0x0000 in order; one VALID per frame; the trailing edge has no effect.
- Phase: frame start aligned to a falling edge, data 0x2001 → correct word, latency ½ cycle; same word aligned to a rising edge → latency 1 cycle.
- Truncated frame: frame restart after 4 pairs, then a full 0x1234 → no output for the partial sample; single VALID with 0x1234.
- Mid-sample reset: RESET_N pulsed low during pair 3 → outputs go to 0 immediately; no VALID until the next full frame, which decodes correctly.
